regfile_write_buffer: RTL and testbench
=======================================

Name: regfile_write_buffer

Overview:
- Write-side companion to the 8x8-bit register file: accepts writeback results from the execute stage and queues them in a small FIFO.
- Drains one entry per cycle onto the register file write port (write_reg / write_data / write_enable).
- Forwards still-pending data to the two operand read ports so decode never sees stale register contents.

Parameters:
- DEPTH, 4, number of queued writes held (power of two, 2..16).
- DATA_W, 8, register data width.
- ADDR_W, 3, register index width (8 registers).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wb_valid  input  1  producer offers a write this cycle.
- wb_reg  input  ADDR_W  destination register of the offered write.
- wb_data  input  DATA_W  data of the offered write.
- wb_ready  output  1  buffer can accept; transfer occurs when wb_valid && wb_ready at a rising edge.
- drain_hold  input  1  when high, no entry is popped this cycle.
- write_reg  output  ADDR_W  to register file write_reg.
- write_data  output  DATA_W  to register file write_data.
- write_enable  output  1  to register file write_enable.
- read_reg1  input  ADDR_W  operand 1 index (shared with register file read_reg1).
- read_reg2  input  ADDR_W  operand 2 index.
- rf_data1  input  DATA_W  register file read_data1.
- rf_data2  input  DATA_W  register file read_data2.
- fwd_data1  output  DATA_W  operand 1 value with pending writes applied.
- fwd_data2  output  DATA_W  operand 2 value with pending writes applied.
- pending_count  output  $clog2(DEPTH+1)  entries currently queued (excludes output stage).
- empty  output  1  pending_count == 0 and write_enable == 0.

Behaviour:
- Reset (async, any time, including mid-drain):
  - pointers and count cleared; write_enable = 0, write_reg = 0, write_data = 0.
  - queued entries are discarded, never written.
  - wb_ready = 1 and empty = 1 in the cycle after reset deasserts.
- Enqueue: on a rising edge with wb_valid && wb_ready, store {wb_reg, wb_data} at the tail; tail wraps modulo DEPTH.
- wb_ready = (pending_count < DEPTH).
  - Combinational from registered state only; no dependence on drain in the same cycle.
  - When full, wb_ready = 0 even if a pop occurs that edge.
- Drain (output stage is registered): at each rising edge,
  - if pending_count > 0 && !drain_hold: write_enable <= 1, {write_reg, write_data} <= head entry; head advances (wraps modulo DEPTH).
  - otherwise write_enable <= 0; write_reg and write_data hold their previous values.
- Latency: a write accepted at edge N drives write_enable from edge N+1 when the queue was empty and not held. The register file commits it at edge N+2.
- Simultaneous enqueue and pop in one edge: both occur; pending_count unchanged.
- Ordering is strict FIFO. Two writes to the same register drain in arrival order; the last one wins in the register file.
- Forwarding is combinational; fwd_dataK is computed per port, newest source first:
  - newest matching valid queue entry (tail-1 back toward head);
  - else the output stage, if write_enable && write_reg == read_regK;
  - else rf_dataK.
- An entry accepted at edge N is visible to forwarding from immediately after edge N.
- pending_count never exceeds DEPTH or underflows.

Optional Feature:
- Macro: REG0_HARDWIRED_EN.
- Defined:
  - register 0 reads as constant zero; a write to register 0 is accepted (wb_ready handshake completes) but not enqueued, and pending_count is unchanged;
  - fwd_dataK = 0 whenever read_regK == 0, regardless of rf_dataK.
- Undefined: register 0 is an ordinary register, queued and forwarded like all others.

Test Plan:
- Reset, then a single write r0 <= 8'hA5 at edge 1 -> write_enable = 1, write_reg = 0, write_data = 8'hA5 after edge 2; empty = 1 after edge 3. With REG0_HARDWIRED_EN defined: no write_enable pulse, and fwd_data1 = 0.
- drain_hold = 1; enqueue r1 <= 8'h5A, r2 <= 8'h11, r3 <= 8'h22, r4 <= 8'h33 -> wb_ready = 0 and pending_count = 4. A fifth offer (r5 <= 8'h44) is not accepted until the first pop after drain_hold drops; drain order is r1, r2, r3, r4, r5.
- drain_hold = 1; enqueue r1 <= 8'h10 then r1 <= 8'h20; read_reg1 = 1, rf_data1 = 8'hFF -> fwd_data1 = 8'h20. Release drain_hold -> two write_enable pulses: 8'h10 then 8'h20.
- Output stage holds r2 <= 8'h3C while the queue holds no r2 entry; read_reg2 = 2, rf_data2 = 8'h00 -> fwd_data2 = 8'h3C. With read_reg2 = 6 -> fwd_data2 = rf_data2.
- Queue of 3 entries draining; assert reset mid-cycle -> write_enable drops immediately to 0, pending_count = 0, no further writes are issued.
- Full queue, wb_valid held high continuously with drain enabled -> one accept per pop; pending_count stays between DEPTH-1 and DEPTH; pointers wrap correctly over 10 or more writes with data 8'h01..8'h0A, delivered in order.

Source files
------------

// File: rtl/regfile_write_buffer.sv
// Write-side FIFO for the 8x8 register file: queues writeback results, drains one per cycle,
// and forwards pending data to the two read ports. Optional macro REG0_HARDWIRED_EN makes r0 read as zero.
module regfile_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wb_valid,
    input  logic [ADDR_W-1:0]            wb_reg,
    input  logic [DATA_W-1:0]            wb_data,
    output logic                         wb_ready,
    input  logic                         drain_hold,
    output logic [ADDR_W-1:0]            write_reg,
    output logic [DATA_W-1:0]            write_data,
    output logic                         write_enable,
    input  logic [ADDR_W-1:0]            read_reg1,
    input  logic [ADDR_W-1:0]            read_reg2,
    input  logic [DATA_W-1:0]            rf_data1,
    input  logic [DATA_W-1:0]            rf_data2,
    output logic [DATA_W-1:0]            fwd_data1,
    output logic [DATA_W-1:0]            fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0]   pending_count,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] q_reg_p0  [DEPTH];
    logic [DATA_W-1:0] q_data_p0 [DEPTH];
    logic [PTR_W-1:0]  head_p0;
    logic [PTR_W-1:0]  tail_p0;
    logic [CNT_W-1:0]  count_p0;

    logic accept;
    logic push;
    logic pop;

    assign wb_ready      = (count_p0 < FULL_CNT);
    assign accept        = wb_valid && wb_ready;
    assign pop           = (count_p0 != '0) && !drain_hold;
    assign pending_count = count_p0;
    assign empty         = (count_p0 == '0) && !write_enable;

`ifdef REG0_HARDWIRED_EN
    // r0 writes complete the handshake but are dropped on the floor
    assign push = accept && (wb_reg != '0);
`else
    assign push = accept;
`endif

    // Stage p0: queue storage (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (push) begin
            q_reg_p0[tail_p0]  <= wb_reg;
            q_data_p0[tail_p0] <= wb_data;
        end
    end

    // Stage p0 control and p1 output stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_p0      <= '0;
            tail_p0      <= '0;
            count_p0     <= '0;
            write_enable <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
        end else begin
            if (push) begin
                tail_p0 <= tail_p0 + 1'b1;
            end
            if (pop) begin
                head_p0      <= head_p0 + 1'b1;
                write_enable <= 1'b1;
                write_reg    <= q_reg_p0[head_p0];
                write_data   <= q_data_p0[head_p0];
            end else begin
                write_enable <= 1'b0;
            end
            count_p0 <= count_p0 + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Forwarding: walk oldest to newest so the newest match overrides
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        fwd_data1 = rf_data1;
        fwd_data2 = rf_data2;
        if (write_enable && (write_reg == read_reg1)) begin
            fwd_data1 = write_data;
        end
        if (write_enable && (write_reg == read_reg2)) begin
            fwd_data2 = write_data;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_p0 + PTR_W'(k);
            if (CNT_W'(k) < count_p0) begin
                if (q_reg_p0[idx] == read_reg1) begin
                    fwd_data1 = q_data_p0[idx];
                end
                if (q_reg_p0[idx] == read_reg2) begin
                    fwd_data2 = q_data_p0[idx];
                end
            end
        end
`ifdef REG0_HARDWIRED_EN
        if (read_reg1 == '0) begin
            fwd_data1 = '0;
        end
        if (read_reg2 == '0) begin
            fwd_data2 = '0;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Randomized and directed bench for regfile_write_buffer against a queue-based reference model.
module tb_regfile_write_buffer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ready;
    logic              drain_hold;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              write_enable;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;
    logic [2:0]        pending_count;
    logic              empty;

    regfile_write_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ready(wb_ready),
        .drain_hold(drain_hold),
        .write_reg(write_reg), .write_data(write_data), .write_enable(write_enable),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .pending_count(pending_count), .empty(empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending writes as {reg,data} in arrival order, plus last drained write
    logic [10:0] q[$];
    logic        m_we;
    logic [2:0]  m_reg;
    logic [7:0]  m_data;
    logic        acc;
    int          nxt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] exp_fwd(input logic [2:0] rr, input logic [7:0] rf);
`ifdef REG0_HARDWIRED_EN
        if (rr == 3'd0) return 8'h00;
`endif
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i][10:8] == rr) return q[i][7:0];
        if (m_we && m_reg == rr) return m_data;
        return rf;
    endfunction

    task automatic model_reset();
        q.delete();
        m_we   = 1'b0;
        m_reg  = 3'd0;
        m_data = 8'h00;
    endtask

    // One clock: drive at negedge, check against model, advance model across the posedge
    task automatic cycle(input logic v, input logic [2:0] r, input logic [7:0] d, input logic h,
                         input logic [2:0] r1, input logic [2:0] r2,
                         input logic [7:0] f1, input logic [7:0] f2, output logic accepted);
        logic pop;
        logic push;
        wb_valid = v; wb_reg = r; wb_data = d; drain_hold = h;
        read_reg1 = r1; read_reg2 = r2; rf_data1 = f1; rf_data2 = f2;
        #1;
        check("wb_ready", wb_ready, q.size() < DEPTH);
        check("pending_count", pending_count, q.size());
        check("empty", empty, (q.size() == 0) && !m_we);
        check("write_enable", write_enable, m_we);
        check("write_reg", write_reg, m_reg);
        check("write_data", write_data, m_data);
        check("fwd_data1", fwd_data1, exp_fwd(r1, f1));
        check("fwd_data2", fwd_data2, exp_fwd(r2, f2));
        accepted = v && (q.size() < DEPTH);
        pop      = (q.size() > 0) && !h;
        push     = accepted;
`ifdef REG0_HARDWIRED_EN
        if (r == 3'd0) push = 1'b0;
`endif
        @(posedge clk);
        if (pop) {m_reg, m_data} = q.pop_front();
        m_we = pop;
        if (push) q.push_back({r, d});
        @(negedge clk);
    endtask

    task automatic idle(input logic h);
        logic a;
        cycle(1'b0, 3'($urandom), 8'($urandom), h, 3'($urandom), 3'($urandom),
              8'($urandom), 8'($urandom), a);
    endtask

    initial begin
        reset = 1'b1;
        wb_valid = 1'b0; wb_reg = '0; wb_data = '0; drain_hold = 1'b0;
        read_reg1 = '0; read_reg2 = '0; rf_data1 = '0; rf_data2 = '0;
        model_reset();
        #2;
        check("rst_we", write_enable, 1'b0);
        check("rst_pending", pending_count, 3'd0);
        check("rst_wdata", write_data, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_ready", wb_ready, 1'b1);
        check("rst_empty", empty, 1'b1);

        // Single write to r0
        cycle(1'b1, 3'd0, 8'hA5, 1'b0, 3'd0, 3'd1, 8'hFF, 8'h00, acc);
        idle(1'b0);
`ifdef REG0_HARDWIRED_EN
        check("r0_no_pulse", write_enable, 1'b0);
`else
        check("r0_we", write_enable, 1'b1);
        check("r0_reg", write_reg, 3'd0);
        check("r0_data", write_data, 8'hA5);
`endif
        idle(1'b0);
        check("r0_empty_after", empty, 1'b1);

        // Fill under hold, fifth offer waits for first pop
        cycle(1'b1, 3'd1, 8'h5A, 1'b1, 3'd1, 3'd2, 8'h00, 8'h00, acc);
        cycle(1'b1, 3'd2, 8'h11, 1'b1, 3'd2, 3'd3, 8'h00, 8'h00, acc);
        cycle(1'b1, 3'd3, 8'h22, 1'b1, 3'd3, 3'd4, 8'h00, 8'h00, acc);
        cycle(1'b1, 3'd4, 8'h33, 1'b1, 3'd4, 3'd1, 8'h00, 8'h00, acc);
        check("full_pending", pending_count, 3'd4);
        check("full_ready", wb_ready, 1'b0);
        cycle(1'b1, 3'd5, 8'h44, 1'b1, 3'd5, 3'd1, 8'h00, 8'h00, acc);
        check("held_offer_refused", acc, 1'b0);
        cycle(1'b1, 3'd5, 8'h44, 1'b0, 3'd5, 3'd1, 8'h00, 8'h00, acc);
        check("pop_edge_refused", acc, 1'b0);
        cycle(1'b1, 3'd5, 8'h44, 1'b0, 3'd5, 3'd1, 8'h00, 8'h00, acc);
        check("fifth_accepted", acc, 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b0);

        // Same-register overwrite forwarding
        cycle(1'b1, 3'd1, 8'h10, 1'b1, 3'd1, 3'd0, 8'hFF, 8'h00, acc);
        cycle(1'b1, 3'd1, 8'h20, 1'b1, 3'd1, 3'd0, 8'hFF, 8'h00, acc);
        #1;
        check("fwd_newest", fwd_data1, 8'h20);
        cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd0, 8'hFF, 8'h00, acc);
        for (int i = 0; i < 3; i++) idle(1'b0);

        // Output-stage forwarding
        cycle(1'b1, 3'd2, 8'h3C, 1'b0, 3'd0, 3'd2, 8'h00, 8'h00, acc);
        cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 8'h00, 8'h00, acc);
        cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, 8'h00, 8'h77, acc);
        idle(1'b0);

        // Reset in the middle of a drain
        cycle(1'b1, 3'd3, 8'hA1, 1'b1, 3'd3, 3'd4, 8'h00, 8'h00, acc);
        cycle(1'b1, 3'd4, 8'hA2, 1'b1, 3'd3, 3'd4, 8'h00, 8'h00, acc);
        cycle(1'b1, 3'd5, 8'hA3, 1'b1, 3'd3, 3'd4, 8'h00, 8'h00, acc);
        cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 3'd4, 8'h00, 8'h00, acc);
        wb_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("midrst_we", write_enable, 1'b0);
        check("midrst_pending", pending_count, 3'd0);
        check("midrst_wreg", write_reg, 3'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) idle(1'b0);

        // Continuous offers against a full queue with wrapping pointers
        nxt = 1;
        for (int c = 0; c < 4; c++) begin
            cycle(1'b1, 3'(nxt), 8'(nxt), 1'b1, 3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), acc);
            if (acc) nxt++;
        end
        for (int c = 0; c < 40 && nxt <= 10; c++) begin
            cycle(1'b1, 3'(nxt), 8'(nxt), 1'b0, 3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), acc);
            if (acc) nxt++;
        end
        check("wrap_all_accepted", nxt, 11);
        for (int i = 0; i < 6; i++) idle(1'b0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 2) != 0, 3'($urandom), 8'($urandom), $urandom_range(0, 3) == 0,
                  3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), acc);
        end
        for (int i = 0; i < 6; i++) idle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
